// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - registered N:1 stream mux with fixed-select and round-robin modes
module rr_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] grant;
  logic             any_req;
  logic             load_en;
  logic             in_xfer;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new word when empty or draining this cycle.
  assign load_en = !out_valid || out_ready;

  // Round-robin search: first requesting channel at or after ptr, wrapping.
  // CHANNELS is a power of two, so SEL_W-bit addition wraps for free.
  always_comb begin
    logic [SEL_W-1:0] idx;
    rr_grant = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = ptr + SEL_W'(k);
      if (!rr_found && in_valid[idx]) begin
        rr_grant = idx;
        rr_found = 1'b1;
      end
    end
  end

  // Pick the grant for the current mode; in_ready never looks at in_data.
  always_comb begin
    grant    = mode ? rr_grant : sel;
    any_req  = mode ? rr_found : in_valid[sel];
    in_xfer  = load_en && any_req;
    in_ready = '0;
    if (in_xfer) in_ready[grant] = 1'b1;
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL_W'(k) == grant) grant_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register and rotating pointer; ptr only advances on round-robin transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
        if (mode) ptr <= grant + SEL_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - self-checking bench for rr_stream_mux
module tb_rr_stream_mux;
  localparam int N = 8;
  localparam int W = 8;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [S-1:0]   sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_chan;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  rr_stream_mux #(.WIDTH(W), .CHANNELS(N), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [S-1:0] sel;
    logic [N-1:0] iv;
    logic         ordy;
    logic [N-1:0] exp_ready;
    logic         exp_ov;
    logic [W-1:0] exp_data;
    logic [S-1:0] exp_chan;
  } vec_t;

  vec_t vecs[$];

  // Fixed per-channel words for the directed table: ch7..ch0.
  localparam logic [N*W-1:0] BASE_DATA = {8'h77, 8'h66, 8'hA5, 8'h44, 8'h3C, 8'h22, 8'h11, 8'h0F};
  logic [W-1:0] base_word [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [S-1:0] s, input logic [N-1:0] iv,
                              input logic o, input logic [N-1:0] r, input logic ov,
                              input logic [S-1:0] ch);
    vec_t v;
    v.mode = m; v.sel = s; v.iv = iv; v.ordy = o;
    v.exp_ready = r; v.exp_ov = ov; v.exp_chan = ch;
    v.exp_data = base_word[ch];
    return v;
  endfunction

  // Reference model state
  int           m_ptr;
  logic         m_ov;
  logic [W-1:0] m_od;
  logic [S-1:0] m_oc;

  initial begin
    logic [N*W-1:0] tmp;
    tmp = BASE_DATA;
    for (int i = 0; i < N; i++) base_word[i] = tmp[i*W +: W];

    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = BASE_DATA; out_ready = 1'b0;
    #2;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data",  32'(out_data),  0);
    chk("reset_out_chan",  32'(out_chan),  0);
    chk("reset_ptr",       32'(dut.ptr),   0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed select: channel 5 from a full request vector.
    vecs.push_back(mk(1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5));
    // Round-robin fairness from ptr=0: 0..7 then 0.
    for (int k = 0; k < 9; k++)
      vecs.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, N'(1) << (k % N), 1'b1, S'(k % N)));
    // ptr now 1; a lone channel-6 request leaves ptr=7.
    vecs.push_back(mk(1'b1, 3'd0, 8'h40, 1'b1, 8'h40, 1'b1, 3'd6));
    // Wrap and sparse skip: 7, 1, 7.
    vecs.push_back(mk(1'b1, 3'd0, 8'h82, 1'b1, 8'h80, 1'b1, 3'd7));
    vecs.push_back(mk(1'b1, 3'd0, 8'h82, 1'b1, 8'h02, 1'b1, 3'd1));
    vecs.push_back(mk(1'b1, 3'd0, 8'h82, 1'b1, 8'h80, 1'b1, 3'd7));
    // Load channel 3 (mode 0 leaves ptr=0), then stall four cycles while inputs churn.
    vecs.push_back(mk(1'b0, 3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3));
    vecs.push_back(mk(1'b1, 3'd1, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3));
    vecs.push_back(mk(1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3));
    vecs.push_back(mk(1'b1, 3'd7, 8'h0F, 1'b0, 8'h00, 1'b1, 3'd3));
    vecs.push_back(mk(1'b0, 3'd3, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3));
    // Release: the next word loads in the same cycle as the drain.
    vecs.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0));
    // Idle drain: out_valid drops, data and chan hold.
    vecs.push_back(mk(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0));
    // Fixed select on a non-requesting channel: nothing granted.
    vecs.push_back(mk(1'b0, 3'd2, 8'hFB, 1'b1, 8'h00, 1'b0, 3'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_out_chan", i),  32'(out_chan),  32'(vecs[i].exp_chan));
    end

    // Asynchronous reset in the middle of a stall discards the held word.
    mode = 1'b1; in_valid = 8'h20; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_loaded", 32'(out_valid), 1);
    out_ready = 1'b0; in_valid = 8'hFF;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_out_data",  32'(out_data),  0);
    chk("async_out_chan",  32'(out_chan),  0);
    chk("async_ptr",       32'(dut.ptr),   0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("held_reset_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1; in_valid = '0;
    @(posedge clk); #1;
    chk("post_reset_no_word", 32'(out_valid), 0);

    // Randomised traffic against a rule-level model.
    m_ptr = 0; m_ov = 1'b0; m_od = '0; m_oc = '0;
    for (int c = 0; c < 600; c++) begin
      int           g;
      logic         req;
      logic         le;
      logic [N-1:0] er;
      mode      = ($urandom_range(0, 3) != 0);
      sel       = S'($urandom);
      in_valid  = ($urandom_range(0, 1) != 0) ? N'($urandom & $urandom & $urandom) : N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);

      le  = !m_ov || out_ready;
      g   = 0;
      req = 1'b0;
      if (!mode) begin
        g   = int'(sel);
        req = in_valid[g];
      end else begin
        for (int k = 0; k < N; k++) begin
          int c2;
          c2 = (m_ptr + k) % N;
          if (!req && in_valid[c2]) begin
            g   = c2;
            req = 1'b1;
          end
        end
      end
      er = (le && req) ? (N'(1) << g) : '0;
      #1;
      chk("rand_in_ready", 32'(in_ready), 32'(er));
      if (le && req) begin
        m_ov = 1'b1;
        m_od = in_data[g*W +: W];
        m_oc = S'(g);
        if (mode) m_ptr = (g + 1) % N;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      @(posedge clk); #1;
      chk("rand_out_valid", 32'(out_valid), 32'(m_ov));
      chk("rand_out_data",  32'(out_data),  32'(m_od));
      chk("rand_out_chan",  32'(out_chan),  32'(m_oc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
